uart_tx_sched: RTL and testbench

//  Round-robin scheduler and 8N1 serializer sharing one UART TX line among N_REQ byte requesters.

---
 rtl/uart_tx_sched.sv | 152 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler plus 8N1 serializer sharing one UART TX line among N_REQ byte requesters.
// Line edges happen only on the baud tick; back-to-back frames leave no idle bit between them.
module uart_tx_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       frame_done
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // state   | meaning
    // S_IDLE  | line high, waiting for any valid requester
    // S_WAIT  | byte accepted, waiting for the tick that drops the start bit
    // S_START | start bit on the line
    // S_DATA  | data bit bit_idx_q on the line (LSB first)
    // S_STOP  | stop bit on the line; may chain straight into the next frame
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_STOP} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]  ready_q, ready_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ID_W-1:0]   pick;
    logic              any_valid;
    logic              accept;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Scanning from the far end down lets the nearest valid index at or after rr_ptr win.
    always_comb begin
        pick      = rr_ptr_q;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_idx(rr_ptr_q, i)]) begin
                pick      = wrap_idx(rr_ptr_q, i);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bit_idx_d = bit_idx_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        ready_d   = '0;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (any_valid) begin
                    accept  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: if (tick) begin
                tx_d    = 1'b0;
                state_d = S_START;
            end
            S_START: if (tick) begin
                tx_d      = data_q[0];
                bit_idx_d = '0;
                state_d   = S_DATA;
            end
            S_DATA: if (tick) begin
                if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    data_d    = data_q >> 1;
                    tx_d      = data_d[0];
                end
            end
            S_STOP: if (tick) begin
                done_d = 1'b1;
                if (any_valid) begin
                    accept  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            ready_d[pick] = 1'b1;
            data_d        = req_data[int'(pick)*DATA_W +: DATA_W];
            grant_d       = pick;
            rr_ptr_d      = wrap_idx(pick, 1);
            busy_d        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            bit_idx_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            ready_q   <= ready_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign req_ready  = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign grant_id   = grant_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: tests queue expected {grant, byte} entries, a monitor
// decodes each serial frame from the line and compares it against the queue head.
module tb_uart_tx_sched;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        tick      = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;

    uart_tx_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         tick_cnt = 0;
    bit         tick_en  = 1'b1;
    logic [9:0] sb_q[$];

    bit         mon_active = 1'b0;
    int         mon_n      = 0;
    int         mon_acc    = 0;
    logic [9:0] mon_bits   = '0;
    logic [7:0] cur_data   = '0;
    logic       last_tx    = 1'b1;
    bit         acc_tick   = 1'b0;
    bit         ended      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; tick fires every 4th cycle while enabled.
    task automatic cyc();
        @(negedge clk);
        tick     = tick_en && (tick_cnt == 3);
        tick_cnt = (tick_cnt + 1) % 4;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (req_ready == '0 && n < 300);
        chk(tag, 32'(req_ready != '0), 1);
    endtask

    task automatic wait_bits(input int k);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(mon_active && mon_n >= k) && n < 300);
        chk("wait_bits", 32'(mon_active && mon_n >= k), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while ((busy || mon_active) && n < 300);
        chk("wait_idle", 32'(busy || mon_active), 0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [9:0] e;
        bit         was_active;
        forever begin
            @(posedge clk);
            #1;
            ended = 1'b0;
            if (!reset) begin
                chk("rst_tx", 32'(tx), 1);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_ready", 32'(req_ready), 0);
                chk("rst_frame_done", 32'(frame_done), 0);
                chk("rst_grant_id", 32'(grant_id), 0);
                mon_active = 1'b0;
                last_tx    = 1'b1;
            end else begin
                was_active = mon_active;
                if (!tick) chk("tx_hold", 32'(tx), 32'(last_tx));
                if (mon_active && tick && mon_n == 10) begin
                    chk("frame_done", 32'(frame_done), 1);
                    chk("frame_bits", 32'(mon_bits), 32'({1'b1, cur_data, 1'b0}));
                    chk("busy_end", 32'(busy), 32'(|req_valid));
                    mon_active = 1'b0;
                    ended      = 1'b1;
                end else begin
                    chk("no_frame_done", 32'(frame_done), 0);
                    if (mon_active && tick) begin
                        mon_bits[mon_n] = tx;
                        mon_n++;
                    end
                end
                if (req_ready != '0) begin
                    if (was_active && !ended) chk("ready_midframe", 32'(req_ready), 0);
                    else if (sb_q.size() == 0) chk("unexpected_ready", 32'(req_ready), 0);
                    else begin
                        e = sb_q.pop_front();
                        chk("ready_onehot", 32'(req_ready), 32'(1) << e[9:8]);
                        chk("grant_id", 32'(grant_id), 32'(e[9:8]));
                        chk("busy_accept", 32'(busy), 1);
                        cur_data   = e[7:0];
                        acc_tick   = tick;
                        mon_active = 1'b1;
                        mon_bits   = '0;
                        mon_acc++;
                        if (ended) begin
                            chk("b2b_start", 32'(tx), 0);
                            mon_n = 1;
                        end else begin
                            chk("idle_tx", 32'(tx), 1);
                            mon_n = 0;
                        end
                    end
                end else if (ended && |req_valid) begin
                    chk("b2b_accept", 32'(req_ready != '0), 1);
                end
                last_tx = tx;
            end
        end
    end

    initial begin
        int frozen_n;
        logic frozen_tx;

        repeat (3) cyc();
        reset = 1'b1;
        repeat (4) cyc();

        // Single frame from requester 2, 8'hA5.
        req_data[2*8 +: 8] = 8'hA5;
        req_valid = 4'b0100;
        sb_q.push_back({2'd2, 8'hA5});
        wait_ready("t2_ready");
        req_valid = '0;
        wait_idle();

        // Reset mid-frame: frame aborted silently, rr_ptr back to 0.
        req_data[2*8 +: 8] = 8'h81;
        req_valid = 4'b0100;
        sb_q.push_back({2'd2, 8'h81});
        wait_ready("t1_ready");
        req_valid = '0;
        wait_bits(3);
        reset = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        repeat (20) cyc();

        // All four valid and held: grants 0,1,2,3 back-to-back then 0 again.
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) sb_q.push_back({2'(i % 4), 8'h10 + 8'(i % 4)});
        for (int i = 0; i < 5; i++) wait_ready("t3_ready");
        req_valid = '0;
        wait_idle();

        // Valid raised in the same cycle as a tick while idle.
        begin
            int n;
            n = 0;
            do begin
                cyc();
                n++;
            end while (!tick && n < 10);
            chk("t4_tick_found", 32'(tick), 1);
        end
        req_data[0 +: 8] = 8'h3C;
        req_valid = 4'b0001;
        sb_q.push_back({2'd0, 8'h3C});
        wait_ready("t4_ready");
        chk("t4_accept_on_tick", 32'(acc_tick), 1);
        req_valid = '0;
        wait_idle();

        // Requester 1 withdraws before the grant; requester 3 must win.
        req_data[0 +: 8] = 8'h5A;
        req_valid = 4'b0001;
        sb_q.push_back({2'd0, 8'h5A});
        wait_ready("t5_first_ready");
        req_data[1*8 +: 8] = 8'hEE;
        req_data[3*8 +: 8] = 8'h77;
        req_valid = 4'b1010;
        sb_q.push_back({2'd3, 8'h77});
        wait_bits(5);
        req_valid = 4'b1000;
        wait_ready("t5_second_ready");
        req_valid = '0;
        wait_idle();

        // Tick stalled for 50 cycles mid-DATA; the frame must resume intact.
        req_data[1*8 +: 8] = 8'hC3;
        req_valid = 4'b0010;
        sb_q.push_back({2'd1, 8'hC3});
        wait_ready("t6_ready");
        req_valid = '0;
        wait_bits(4);
        tick_en   = 1'b0;
        frozen_n  = mon_n;
        frozen_tx = tx;
        repeat (50) cyc();
        chk("t6_frozen_bits", 32'(mon_n), 32'(frozen_n));
        chk("t6_frozen_tx", 32'(tx), 32'(frozen_tx));
        tick_en = 1'b1;
        wait_idle();
        repeat (10) cyc();

        chk("sb_empty", 32'(sb_q.size()), 0);
        chk("accept_count", 32'(mon_acc), 11);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
